// File: rtl/reaction_delay_gen.sv
// Reaction-timer delay generator: an LFSR-randomised wait counted in divided ticks, then GO.
// Optional false-start detection in COUNT is built when FALSE_START_EN is defined.
module reaction_delay_gen #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned DELAY_W   = 11,
  parameter int unsigned RAND_W    = 10,
  parameter int unsigned MIN_DELAY = 1024,
  parameter int unsigned NUM_KEYS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [DELAY_W-1:0]  delay_q,
  output logic                go,
  output logic                fault,
  output logic [NUM_KEYS-1:0] fault_key,
  output logic [2:0]          state_q
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COUNT = 3'd2,
    S_GO    = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  // Feedback taps (1-based bit positions) of maximal-length polynomials, XOR form.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    logic [31:0] m;
    case (w)
      3:       m = (32'd1 << 2)  | (32'd1 << 1);
      4:       m = (32'd1 << 3)  | (32'd1 << 2);
      5:       m = (32'd1 << 4)  | (32'd1 << 2);
      6:       m = (32'd1 << 5)  | (32'd1 << 4);
      7:       m = (32'd1 << 6)  | (32'd1 << 5);
      8:       m = (32'd1 << 7)  | (32'd1 << 5)  | (32'd1 << 4)  | (32'd1 << 3);
      9:       m = (32'd1 << 8)  | (32'd1 << 4);
      10:      m = (32'd1 << 9)  | (32'd1 << 6);
      11:      m = (32'd1 << 10) | (32'd1 << 8);
      12:      m = (32'd1 << 11) | (32'd1 << 5)  | (32'd1 << 3)  | (32'd1 << 0);
      13:      m = (32'd1 << 12) | (32'd1 << 3)  | (32'd1 << 2)  | (32'd1 << 0);
      14:      m = (32'd1 << 13) | (32'd1 << 4)  | (32'd1 << 2)  | (32'd1 << 0);
      15:      m = (32'd1 << 14) | (32'd1 << 13);
      16:      m = (32'd1 << 15) | (32'd1 << 14) | (32'd1 << 12) | (32'd1 << 3);
      17:      m = (32'd1 << 16) | (32'd1 << 13);
      18:      m = (32'd1 << 17) | (32'd1 << 10);
      19:      m = (32'd1 << 18) | (32'd1 << 5)  | (32'd1 << 1)  | (32'd1 << 0);
      20:      m = (32'd1 << 19) | (32'd1 << 16);
      default: m = (32'd1 << (w - 1)) | (32'd1 << (w - 2));
    endcase
    return m;
  endfunction

  localparam logic [31:0]        TAPS32    = tap_mask(RAND_W);
  localparam logic [RAND_W-1:0]  TAPS      = TAPS32[RAND_W-1:0];
  localparam logic [32:0]        DELAY_MAX = (33'd1 << DELAY_W) - 33'd1;

  state_t              state, state_d;
  logic [RAND_W-1:0]   lfsr;
  logic [DELAY_W-1:0]  cnt, cnt_d, delay_d;
  logic [DIV_W-1:0]    div, div_d;
  logic [32:0]         sum_full;
  logic                tick;

  assign sum_full = 33'(MIN_DELAY) + 33'(lfsr);
  assign tick     = (state == S_COUNT) && (div == DIV_W'(CLK_DIV - 1));
  assign state_q  = state;

  // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= RAND_W'(1);
    else     lfsr <= {lfsr[RAND_W-2:0], ^(lfsr & TAPS)};
  end

`ifdef FALSE_START_EN
  logic [NUM_KEYS-1:0] fault_key_d;
`endif

  // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    div_d   = div;
    delay_d = delay_q;
`ifdef FALSE_START_EN
    fault_key_d = fault_key;
`endif
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        div_d = '0;
`ifdef FALSE_START_EN
        fault_key_d = '0;
`endif
        if (en) begin
          state_d = S_LOAD;
          delay_d = (sum_full > DELAY_MAX) ? '1 : sum_full[DELAY_W-1:0];
        end
      end
      S_LOAD: begin
        cnt_d   = delay_q;
        div_d   = '0;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        // Expiry wins over a simultaneous key press.
        if (cnt == '0) state_d = S_GO;
`ifdef FALSE_START_EN
        else if (!(&key_n)) begin
          state_d     = S_FAULT;
          fault_key_d = ~key_n;
        end
`endif
        else if (tick) begin
          cnt_d = cnt - DELAY_W'(1);
          div_d = '0;
        end else begin
          div_d = div + DIV_W'(1);
        end
      end
      S_GO, S_FAULT: state_d = state;
      default:       state_d = S_IDLE;
    endcase

    if ((state != S_IDLE) && !en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      div_d   = '0;
`ifdef FALSE_START_EN
      fault_key_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div     <= '0;
      delay_q <= '0;
      go      <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      div     <= div_d;
      delay_q <= delay_d;
      go      <= (state_d == S_GO);
    end
  end

`ifdef FALSE_START_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault     <= 1'b0;
      fault_key <= '0;
    end else begin
      fault     <= (state_d == S_FAULT);
      fault_key <= fault_key_d;
    end
  end
`else
  // Keys only matter for false-start detection; without it they are deliberately unused.
  logic unused_keys;
  assign unused_keys = &key_n;
  assign fault       = 1'b0;
  assign fault_key   = '0;
`endif

endmodule

// File: tb/tb_reaction_delay_gen.sv
// Self-checking bench for reaction_delay_gen: randomised rounds scored against a cycle-count model.
// Expectations follow FALSE_START_EN when the bench is compiled with it defined.
module tb_reaction_delay_gen;

  localparam int C  = 4;
  localparam int DW = 5;
  localparam int MN = 8;

  logic        clk, rst, en, en_s;
  logic [1:0]  key_n, key_n_s;
  logic [4:0]  delay_q;
  logic        go, fault;
  logic [1:0]  fault_key;
  logic [2:0]  state_q;
  logic [3:0]  delay_q_s;
  logic        go_s, fault_s;
  logic [1:0]  fault_key_s;
  logic [2:0]  state_q_s;

  int checks = 0;
  int errors = 0;
  int n_edges;

  reaction_delay_gen #(.CLK_DIV(C), .DELAY_W(DW), .RAND_W(3), .MIN_DELAY(MN), .NUM_KEYS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .key_n(key_n), .delay_q(delay_q), .go(go),
    .fault(fault), .fault_key(fault_key), .state_q(state_q)
  );

  reaction_delay_gen #(.CLK_DIV(C), .DELAY_W(4), .RAND_W(3), .MIN_DELAY(12), .NUM_KEYS(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en_s), .key_n(key_n_s), .delay_q(delay_q_s), .go(go_s),
    .fault(fault_s), .fault_key(fault_key_s), .state_q(state_q_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since reset released; the LFSR advances once per edge.
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  // Orbit of the 3-bit maximal-length register (x^3+x^2+1) starting from seed 1.
  int lfsr_seq [7] = '{1, 2, 5, 3, 7, 6, 4};

  function automatic int lfsr_now();
    return lfsr_seq[n_edges % 7];
  endfunction

  function automatic int exp_delay(input int lf, input int dw, input int mn);
    int mx;
    mx = (1 << dw) - 1;
    return (mn + lf > mx) ? mx : mn + lf;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_lfsr(input int value);
    for (int i = 0; i < 8 && lfsr_now() != value; i++) step();
  endtask

  // Raises en in IDLE; returns at COUNT entry (two edges later).
  task automatic start_round(output int d);
    d  = exp_delay(lfsr_now(), DW, MN);
    en = 1'b1;
    step();
    checks++;
    if ({state_q, delay_q} !== {3'd1, d[4:0]}) begin
      errors++;
      $display("FAIL load: state/delay got %0d/%0d want 1/%0d", state_q, delay_q, d);
    end
    step();
    checks++;
    if (state_q !== 3'd2) begin
      errors++;
      $display("FAIL count_entry: state got %0d want 2", state_q);
    end
  endtask

  // From COUNT entry (step 2): optionally press keys at absolute step key_at, then hold and end the round.
  task automatic run_round(input int d, input int key_at, input logic [1:0] mask);
    int s, rise, exp_step;
    bit fs;
    logic [4:0] exp_flags;
    fs = 1'b0;
`ifdef FALSE_START_EN
    fs = (key_at >= 2) && (key_at <= d * C + 1);
`endif
    exp_step  = fs ? key_at + 1 : d * C + 3;
    exp_flags = fs ? {3'd4, 1'b0, 1'b1} : {3'd3, 1'b1, 1'b0};
    s = 2;
    rise = -1;
    while (s < d * C + 12 && rise < 0) begin
      if (s == key_at) key_n = ~mask;
      step();
      s++;
      if (go || fault) rise = s;
    end
    checks++;
    if (rise != exp_step) begin
      errors++;
      $display("FAIL outcome_time: go/fault at step %0d want %0d (delay %0d)", rise, exp_step, d);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({state_q, go, fault, fault_key} !== {exp_flags, fs ? mask : 2'b00}) begin
        errors++;
        $display("FAIL outcome_hold: state/go/fault/key got %0d/%0b/%0b/%b want %0d/%0b/%0b/%b",
                 state_q, go, fault, fault_key, exp_flags[4:2], exp_flags[1], exp_flags[0],
                 fs ? mask : 2'b00);
      end
      key_n = 2'($urandom);
      step();
    end
    key_n = 2'b11;
    en    = 1'b0;
    step();
    checks++;
    if ({state_q, go, fault, fault_key, delay_q} !== {3'd0, 1'b0, 1'b0, 2'b00, d[4:0]}) begin
      errors++;
      $display("FAIL en_drop: state/go/fault/key/delay got %0d/%0b/%0b/%b/%0d want 0/0/0/00/%0d",
               state_q, go, fault, fault_key, delay_q, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({state_q, go, fault, fault_key, delay_q, delay_q_s} !== '0) begin
        errors++;
        $display("FAIL reset_idle: state/go/delay got %0d/%0b/%0d want 0/0/0", state_q, go, delay_q);
      end
    end
  endtask

  task automatic test_go_timing();
    int d;
    wait_lfsr(5);
    start_round(d);
    checks++;
    if (delay_q !== 5'd13) begin
      errors++;
      $display("FAIL delay_lfsr5: got %0d want 13", delay_q);
    end
    run_round(d, -1, 2'b00);
  endtask

  task automatic test_false_start();
    int d;
    start_round(d);
    run_round(d, 12, 2'b10);
  endtask

  task automatic test_cnt_zero_key();
    int d;
    start_round(d);
    run_round(d, d * C + 2, 2'b11);
  endtask

  task automatic test_saturation();
    wait_lfsr(7);
    en_s = 1'b1;
    step();
    checks++;
    if (delay_q_s !== 4'd15) begin
      errors++;
      $display("FAIL saturate: got %0d want 15", delay_q_s);
    end
    en_s = 1'b0;
    step();
    wait_lfsr(2);
    en_s = 1'b1;
    step();
    checks++;
    if (delay_q_s !== 4'd14) begin
      errors++;
      $display("FAIL no_saturate: got %0d want 14", delay_q_s);
    end
    en_s = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int d, d2;
    start_round(d);
    repeat (5) step();
    en = 1'b0;
    step();
    checks++;
    if ({state_q, go, delay_q} !== {3'd0, 1'b0, d[4:0]}) begin
      errors++;
      $display("FAIL abort_en: state/go/delay got %0d/%0b/%0d want 0/0/%0d", state_q, go, delay_q, d);
    end
    start_round(d2);
    repeat (6) step();
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++;
    if ({state_q, go, delay_q} !== '0) begin
      errors++;
      $display("FAIL abort_rst: state/go/delay got %0d/%0b/%0d want 0/0/0", state_q, go, delay_q);
    end
    step();
    rst = 1'b0;
    start_round(d);
    checks++;
    if (delay_q !== 5'd9) begin
      errors++;
      $display("FAIL reseed: got %0d want 9", delay_q);
    end
    run_round(d, -1, 2'b00);
  endtask

  task automatic test_random_rounds();
    int d, key_at;
    logic [1:0] mask;
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 8)) step();
      start_round(d);
      key_at = ($urandom_range(0, 2) != 0) ? int'($urandom_range(2, d * C + 2)) : -1;
      mask   = 2'($urandom_range(1, 3));
      run_round(d, key_at, mask);
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    en_s    = 1'b0;
    key_n   = 2'b11;
    key_n_s = 2'b11;
    test_reset();
    test_go_timing();
    test_false_start();
    test_cnt_zero_key();
    test_saturation();
    test_random_rounds();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
